// File: rtl/ikaopll_phasemod_pkg.sv
`default_nettype none
// ============================================================================
// ikaopll_phasemod_pkg : shared OPLL frame/width constants and slot helpers
// Rev 1.0
// ============================================================================
package ikaopll_phasemod_pkg;

  localparam int C_NUM_SLOTS = 18;
  localparam int C_NUM_CH    = 9;
  localparam int C_PHASE_W   = 10;
  localparam int C_OPOUT_W   = 12;
  localparam int C_SLOT_W    = 5;
  localparam int C_CH_W      = 4;
  localparam int C_LSADDR_W  = 8;

  localparam logic [C_CH_W-1:0]   C_LAST_CH   = 4'(C_NUM_CH - 1);
  localparam logic [C_SLOT_W-1:0] C_LAST_SLOT = 5'(C_NUM_SLOTS - 1);

  // Slot parity selects the operator role: even = modulator, odd = carrier
  typedef enum logic [0:0] {
    SLOT_MOD = 1'b0,
    SLOT_CAR = 1'b1
  } slot_kind_e;

  function automatic logic [C_SLOT_W-1:0] next_slot(input logic [C_SLOT_W-1:0] s);
    return (s == C_LAST_SLOT) ? '0 : s + 5'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ikaopll_phasemod_fbmem.sv
`default_nettype none
// ============================================================================
// ikaopll_fbmem : 9 x {cur, prev} operator-output history, 1W / 1 async R
// Rev 1.0
// ============================================================================
module ikaopll_fbmem
  import ikaopll_phasemod_pkg::*;
(
  input  logic                 i_EMUCLK,
  input  logic                 i_RST,
  input  logic                 i_wr_en,
  input  logic [C_CH_W-1:0]    i_wr_ch,
  input  logic [C_OPOUT_W-1:0] i_wr_data,
  input  logic [C_CH_W-1:0]    i_rd_ch,
  output logic [C_OPOUT_W-1:0] o_rd_cur,
  output logic [C_OPOUT_W-1:0] o_rd_prev
);

  logic [C_OPOUT_W-1:0] r_cur  [C_NUM_CH];
  logic [C_OPOUT_W-1:0] r_prev [C_NUM_CH];

  logic w_wr_ok;
  logic w_rd_ok;

  assign w_wr_ok = i_wr_en && (i_wr_ch <= C_LAST_CH);
  assign w_rd_ok = (i_rd_ch <= C_LAST_CH);

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        r_cur[i]  <= '0;
        r_prev[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_prev[i_wr_ch] <= r_cur[i_wr_ch];
      r_cur[i_wr_ch]  <= i_wr_data;
    end
  end

  // Reads see the registered contents only, so a same-cycle write is not bypassed
  assign o_rd_cur  = w_rd_ok ? r_cur[i_rd_ch]  : '0;
  assign o_rd_prev = w_rd_ok ? r_prev[i_rd_ch] : '0;

endmodule
`default_nettype wire

// File: rtl/ikaopll_phasemod.sv
`default_nettype none
// ============================================================================
// ikaopll_phasemod : feedback/modulation phase adder and log-sin address stage
// Rev 1.0
// ============================================================================
module ikaopll_phasemod
  import ikaopll_phasemod_pkg::*;
#(
  parameter int CARRIER_SHIFT = 1
) (
  input  logic                  i_EMUCLK,
  input  logic                  i_RST,
  input  logic                  i_phi1_NCEN_n,
  input  logic                  i_CYCLE_00,
  input  logic [C_PHASE_W-1:0]  i_OP_PHASE,
  input  logic [2:0]            i_FB,
  input  logic [C_OPOUT_W-1:0]  i_OP_OUT,
  input  logic                  i_OP_OUT_WR,
  input  logic [C_CH_W-1:0]     i_OP_OUT_CH,
  output logic [C_LSADDR_W-1:0] o_LS_ADDR,
  output logic                  o_SIGN,
  output logic [C_SLOT_W-1:0]   o_SLOT
);

  logic                  w_en;
  logic [C_SLOT_W-1:0]   w_slot;
  slot_kind_e            w_kind;
  logic [C_OPOUT_W-1:0]  w_cur;
  logic [C_OPOUT_W-1:0]  w_prev;
  logic signed [12:0]    w_sum;
  logic [3:0]            w_fb_shift;
  logic [C_PHASE_W-1:0]  w_mod_fb;
  logic [C_PHASE_W-1:0]  w_mod_car;
  logic [C_PHASE_W-1:0]  w_mod;
  logic [C_PHASE_W-1:0]  w_p;

  logic [C_SLOT_W-1:0]   r_slot;
  logic [C_PHASE_W-1:0]  r_s1_p;
  logic [C_SLOT_W-1:0]   r_s1_slot;
  logic [C_LSADDR_W-1:0] r_ls_addr;
  logic                  r_sign;
  logic [C_SLOT_W-1:0]   r_slot_out;

  assign w_en = ~i_phi1_NCEN_n;

  // r_slot holds the slot of the previous enabled cycle; CYCLE_00 forces this cycle to slot 0
  assign w_slot = i_CYCLE_00 ? '0 : next_slot(r_slot);
  assign w_kind = slot_kind_e'(w_slot[0]);

  ikaopll_fbmem u_fbmem (
    .i_EMUCLK  (i_EMUCLK),
    .i_RST     (i_RST),
    .i_wr_en   (w_en && i_OP_OUT_WR),
    .i_wr_ch   (i_OP_OUT_CH),
    .i_wr_data (i_OP_OUT),
    .i_rd_ch   (w_slot[C_SLOT_W-1:1]),
    .o_rd_cur  (w_cur),
    .o_rd_prev (w_prev)
  );

  assign w_sum      = {w_cur[C_OPOUT_W-1], w_cur} + {w_prev[C_OPOUT_W-1], w_prev};
  assign w_fb_shift = 4'd9 - {1'b0, i_FB};
  assign w_mod_fb   = 10'(w_sum >>> w_fb_shift);
  assign w_mod_car  = 10'($signed(w_cur) >>> CARRIER_SHIFT);

  always_comb begin
    w_mod = '0;
    if (w_kind == SLOT_CAR) begin
      w_mod = w_mod_car;
    end else if (i_FB != 3'd0) begin
      w_mod = w_mod_fb;
    end
  end

  assign w_p = i_OP_PHASE + w_mod;

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      r_slot     <= '0;
      r_s1_p     <= '0;
      r_s1_slot  <= '0;
      r_ls_addr  <= '0;
      r_sign     <= 1'b0;
      r_slot_out <= '0;
    end else if (w_en) begin
      r_slot     <= w_slot;
      r_s1_p     <= w_p;
      r_s1_slot  <= w_slot;
      // Second half of each half-wave mirrors the quarter-wave table
      r_ls_addr  <= r_s1_p[8] ? ~r_s1_p[7:0] : r_s1_p[7:0];
      r_sign     <= r_s1_p[9];
      r_slot_out <= r_s1_slot;
    end
  end

  assign o_LS_ADDR = r_ls_addr;
  assign o_SIGN    = r_sign;
  assign o_SLOT    = r_slot_out;

endmodule
`default_nettype wire
